booth_multiplier_seq: RTL and testbench
=======================================

Name: booth_multiplier_seq

Overview:
- Multi-cycle signed multiplier; the ALU's counterpart to the divider for MUL instructions.
- Radix-4 Booth recoding: retires 2 multiplier bits per clock and produces a full 2*WIDTH-bit product split into HI/LO halves.
- The control unit drives it with a start/done handshake and stalls on busy.

Parameters:
- WIDTH, 32, operand width in bits; must be even and >= 4.

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only while idle
- multiplicand  in  WIDTH  operand M, two's complement
- multiplier  in  WIDTH  operand Q, two's complement
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse; product valid
- product_hi  out  WIDTH  upper half of the product
- product_lo  out  WIDTH  lower half of the product

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; busy=0, done=0, product_hi=0, product_lo=0; internal A, Q, q_m1 and the counter are cleared.
  - Reset wins over every other event, including reset mid-operation: the operation is abandoned and no done pulse occurs.
- FSM has two states, IDLE and RUN.
- IDLE, start=1 at edge E0:
  - Latch M (sign-extended to WIDTH+2 bits).
  - Q=multiplier, q_m1=0, A=0 (WIDTH+2 bits), count=WIDTH/2.
  - Go to RUN; busy=1 after E0.
- RUN, each edge:
  - Recode {Q[1],Q[0],q_m1}: 000/111 -> +0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - A = A + term, computed in WIDTH+2 bits with wrap-around.
  - Arithmetic right shift of {A,Q,q_m1} by 2; sign of A replicated.
  - count decrements.
- Completion (count reaches 0) at edge E(WIDTH/2):
  - product_hi = A[WIDTH-1:0], product_lo = Q.
  - done=1 and busy=0 for that cycle; state=IDLE.
- Latency:
  - With WIDTH=32, done is high in the cycle after E16, i.e. 16 cycles after the accepting edge.
  - No data-dependent early exit.
- done is a single-cycle pulse. product_hi/product_lo hold their values until the next completion or reset; they do not change during RUN.
- start while busy=1 is ignored; operands are not resampled.
- start in the same cycle done=1 is accepted, giving back-to-back operations with no idle gap.
- Operands must be stable only at the accepting edge.
- Results are exact for all inputs, including most-negative operands: (-2^(W-1))^2 = 2^(2W-2).

Optional Feature:
- Macro: BOOTH_MUL_UNSIGNED_EN.
- Defined:
  - Adds port is_unsigned, in, 1, sampled with start.
  - When is_unsigned=1, operands are zero-extended to WIDTH+2 bits and WIDTH/2+1 iterations run, so done comes one cycle later (17 cycles for WIDTH=32).
  - The final product is taken from the shifted register so the 2*WIDTH-bit unsigned product is exact.
  - When is_unsigned=0, behaviour and latency are identical to the signed-only build.
- Undefined: port absent; signed only.

Test Plan:
- Reset, then start with M=6, Q=7 -> busy=1 for 16 cycles; done pulses once; product_hi=0x00000000, product_lo=0x0000002A.
- M=-5 (0xFFFFFFFB), Q=3 -> product_hi=0xFFFFFFFF, product_lo=0xFFFFFFF1.
- Extreme operands:
  - M=Q=0x80000000 -> hi=0x40000000, lo=0x00000000.
  - M=Q=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
- Start held during RUN with new operands -> ignored, first result unchanged; start asserted in the done cycle with M=2, Q=-1 -> next done 16 cycles later with hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- Reset asserted at cycle 8 of RUN -> next cycle busy=0, done=0, products=0; no done pulse follows.
- BOOTH_MUL_UNSIGNED_EN defined, is_unsigned=1, M=Q=0xFFFFFFFF -> done after 17 cycles, hi=0xFFFFFFFE, lo=0x00000001; same operands with is_unsigned=0 -> hi=0x00000000, lo=0x00000001 after 16 cycles.

Source files
------------

// File: rtl/booth_multiplier_seq_if.sv
// booth_multiplier_seq_if
// Start/done handshake and operand/result bus between the control unit and
// the sequential Booth multiplier.
//   master : control unit   (drives start, operands; observes busy/done/product)
//   slave  : multiplier     (observes start, operands; drives busy/done/product)
// Optional macro BOOTH_MUL_UNSIGNED_EN adds the is_unsigned request qualifier.
interface booth_multiplier_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
`ifdef BOOTH_MUL_UNSIGNED_EN
    logic             is_unsigned;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product_hi;
    logic [WIDTH-1:0] product_lo;

    modport master (
        output start, multiplicand, multiplier,
`ifdef BOOTH_MUL_UNSIGNED_EN
        output is_unsigned,
`endif
        input  busy, done, product_hi, product_lo
    );

    modport slave (
        input  start, multiplicand, multiplier,
`ifdef BOOTH_MUL_UNSIGNED_EN
        input  is_unsigned,
`endif
        output busy, done, product_hi, product_lo
    );
endinterface

// File: rtl/booth_multiplier_seq.sv
// booth_multiplier_seq
// Multi-cycle radix-4 Booth multiplier: retires two multiplier bits per clock
// and returns the full 2*WIDTH-bit product as product_hi/product_lo.
// Ports:
//   clock  : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : booth_multiplier_seq_if.slave (start, multiplicand, multiplier,
//            busy, done, product_hi, product_lo [, is_unsigned])
// Optional macro BOOTH_MUL_UNSIGNED_EN: adds is_unsigned; unsigned requests
// zero-extend the operands and run one extra iteration.
//
// state | meaning
// IDLE  | waiting for start; done pulses here for one cycle after completion
// RUN   | one Booth iteration per clock, count down to terminal count
module booth_multiplier_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    booth_multiplier_seq_if.slave bus
);
    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH / 2 + 2);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [AW-1:0]    m_reg;
    logic [AW-1:0]    a_reg;
    // Q carries two extension bits above the multiplier so the unsigned mode
    // has zero digits to recode on its extra iteration.
    logic [AW-1:0]    q_reg;
    logic             q_m1;
    logic [CW-1:0]    count;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
`ifdef BOOTH_MUL_UNSIGNED_EN
    logic             uns_reg;
`endif

    logic [AW-1:0]    term;
    logic [AW-1:0]    sum;
    logic [2*AW:0]    shifted;
    logic [AW-1:0]    a_nxt;
    logic [AW-1:0]    q_nxt;
    logic             q_m1_nxt;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;

    always_comb begin
        term = '0;
        case ({q_reg[1:0], q_m1})
            3'b001, 3'b010: term = m_reg;
            3'b011:         term = m_reg << 1;
            3'b100:         term = -(m_reg << 1);
            3'b101, 3'b110: term = -m_reg;
            default:        term = '0;
        endcase
        sum     = a_reg + term;
        shifted = $signed({sum, q_reg, q_m1}) >>> 2;
        {a_nxt, q_nxt, q_m1_nxt} = shifted;

        // Signed: the extension bits sit just below A, so the low half is
        // Q[W+1:2]. Unsigned shifts two more places, leaving the product
        // aligned at bit 0 of Q.
        hi_nxt = a_nxt[WIDTH-1:0];
        lo_nxt = q_nxt[AW-1:2];
`ifdef BOOTH_MUL_UNSIGNED_EN
        if (uns_reg) begin
            hi_nxt = {a_nxt[WIDTH-3:0], q_nxt[AW-1:WIDTH]};
            lo_nxt = q_nxt[WIDTH-1:0];
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            m_reg  <= '0;
            a_reg  <= '0;
            q_reg  <= '0;
            q_m1   <= 1'b0;
            count  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
`ifdef BOOTH_MUL_UNSIGNED_EN
            uns_reg <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_reg  <= '0;
                        q_m1   <= 1'b0;
                        busy_r <= 1'b1;
                        state  <= RUN;
`ifdef BOOTH_MUL_UNSIGNED_EN
                        uns_reg <= bus.is_unsigned;
                        if (bus.is_unsigned) begin
                            m_reg <= {2'b00, bus.multiplicand};
                            q_reg <= {2'b00, bus.multiplier};
                            count <= CW'(WIDTH / 2 + 1);
                        end else begin
                            m_reg <= {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
                            q_reg <= {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier};
                            count <= CW'(WIDTH / 2);
                        end
`else
                        m_reg <= {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
                        q_reg <= {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier};
                        count <= CW'(WIDTH / 2);
`endif
                    end
                end
                RUN: begin
                    a_reg <= a_nxt;
                    q_reg <= q_nxt;
                    q_m1  <= q_m1_nxt;
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        hi_r   <= hi_nxt;
                        lo_r   <= lo_nxt;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.product_hi = hi_r;
    assign bus.product_lo = lo_r;
endmodule

// File: tb/tb_booth_multiplier_seq.sv
module tb_booth_multiplier_seq;
    localparam int WIDTH = 32;

    typedef struct {
        logic [63:0] prod;
        int          lat;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    int   run_cnt = 0;
    logic [63:0] held = '0;

    booth_multiplier_seq_if #(.WIDTH(WIDTH)) bus ();

    booth_multiplier_seq #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    function automatic void push_exp(input logic [31:0] m, input logic [31:0] q, input bit uns);
        exp_t e;
        logic signed [63:0] sm;
        logic signed [63:0] sq;
        if (uns) begin
            e.prod = {32'b0, m} * {32'b0, q};
            e.lat  = 17;
        end else begin
            sm = $signed(m);
            sq = $signed(q);
            e.prod = sm * sq;
            e.lat  = 16;
        end
        sb.push_back(e);
    endfunction

    // Scoreboard / protocol monitor, sampled mid-cycle.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            run_cnt = 0;
            held = {bus.product_hi, bus.product_lo};
        end else begin
            if (bus.busy) begin
                run_cnt++;
                check("hold", {bus.product_hi, bus.product_lo}, held);
            end else begin
                held = {bus.product_hi, bus.product_lo};
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 64'(bus.done), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("product", {bus.product_hi, bus.product_lo}, e.prod);
                    check("latency", 64'(run_cnt), 64'(e.lat));
                    check("busy_at_done", 64'(bus.busy), 64'(0));
                end
                run_cnt = 0;
            end
        end
    end

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clock);
        @(negedge clock);
        check(tag, 64'(sb.size()), 64'(0));
    endtask

    task automatic op(input logic [31:0] m, input logic [31:0] q, input bit uns);
        @(posedge clock); #1;
        bus.start        = 1'b1;
        bus.multiplicand = m;
        bus.multiplier   = q;
`ifdef BOOTH_MUL_UNSIGNED_EN
        bus.is_unsigned  = uns;
`endif
        push_exp(m, q, uns);
        @(posedge clock); #1;
        bus.start = 1'b0;
        wait_drain("op_timeout");
    endtask

    initial begin
        bit seen;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
`ifdef BOOTH_MUL_UNSIGNED_EN
        bus.is_unsigned  = 1'b0;
`endif
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_state", {30'b0, bus.busy, bus.done, bus.product_hi}, 64'(0));
        check("reset_lo", 64'(bus.product_lo), 64'(0));
        #1 reset = 1'b0;

        // Busy during the first op right after acceptance.
        @(posedge clock); #1;
        bus.start = 1'b1; bus.multiplicand = 32'd6; bus.multiplier = 32'd7;
        push_exp(32'd6, 32'd7, 1'b0);
        @(posedge clock); #1;
        bus.start = 1'b0;
        check("busy_after_accept", 64'(bus.busy), 64'(1));
        wait_drain("op_timeout");
        check("plan_6x7", {bus.product_hi, bus.product_lo}, 64'h0000_0000_0000_002A);

        op(32'hFFFF_FFFB, 32'd3, 1'b0);
        check("plan_m5x3", {bus.product_hi, bus.product_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        op(32'h8000_0000, 32'h8000_0000, 1'b0);
        check("plan_minmin", {bus.product_hi, bus.product_lo}, 64'h4000_0000_0000_0000);
        op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        op(32'h0000_0000, 32'h8000_0000, 1'b0);
        op(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);

        // start held through RUN with changing operands, then back-to-back.
        @(posedge clock); #1;
        bus.start = 1'b1; bus.multiplicand = 32'd1234; bus.multiplier = -32'sd77;
        push_exp(32'd1234, -32'sd77, 1'b0);
        @(posedge clock); #1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                bus.multiplicand = 32'd2;
                bus.multiplier   = 32'hFFFF_FFFF;
                push_exp(32'd2, 32'hFFFF_FFFF, 1'b0);
            end else begin
                bus.multiplicand = $urandom;
                bus.multiplier   = $urandom;
                @(posedge clock); #1;
            end
        end
        check("b2b_done_seen", 64'(seen), 64'(1));
        @(posedge clock); #1;
        bus.start = 1'b0;
        check("b2b_busy", 64'(bus.busy), 64'(1));
        wait_drain("b2b_timeout");
        check("plan_2xm1", {bus.product_hi, bus.product_lo}, 64'hFFFF_FFFF_FFFF_FFFE);

        // Reset mid-operation abandons the op.
        @(posedge clock); #1;
        bus.start = 1'b1; bus.multiplicand = 32'd99; bus.multiplier = 32'd101;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        check("mid_reset", {30'b0, bus.busy, bus.done, bus.product_hi}, 64'(0));
        check("mid_reset_lo", 64'(bus.product_lo), 64'(0));
        reset = 1'b0;
        repeat (30) @(posedge clock);

        for (int i = 0; i < 6; i++) op($urandom, $urandom, 1'b0);

`ifdef BOOTH_MUL_UNSIGNED_EN
        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        check("plan_uns_ff", {bus.product_hi, bus.product_lo}, 64'hFFFF_FFFE_0000_0001);
        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("plan_sgn_ff", {bus.product_hi, bus.product_lo}, 64'h0000_0000_0000_0001);
        op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 4; i++) op($urandom, $urandom, 1'b1);
`endif

        repeat (5) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
